// File: rtl/image_rom_arbiter.sv
// Two-port arbiter in front of the single synchronous-read port of image_rom.
// Define ARB_STARVE_GUARD_EN to enable the aux starvation counter and forced aux grant.
module image_rom_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 12,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic              i_pclk,
  input  logic              i_rst,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_rgb,
  output logic              o_disp_valid,
  output logic              o_disp_miss,
  input  logic              i_aux_req,
  input  logic [ADDR_W-1:0] i_aux_addr,
  output logic              o_aux_gnt,
  output logic [DATA_W-1:0] o_aux_rgb,
  output logic              o_aux_valid,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_rgb
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_AUX  = 2'd2,
    TAG_MISS = 2'd3
  } tag_t;

  logic                   w_force;
  logic                   w_aux_gnt;
  logic                   w_disp_gnt;
  tag_t                   w_tag_in;
  logic [ROM_LAT:0][1:0]  r_tag;
  logic [ADDR_W-1:0]      r_rom_addr;
  logic [DATA_W-1:0]      r_disp_rgb;
  logic [DATA_W-1:0]      r_aux_rgb;
  logic                   r_disp_valid;
  logic                   r_aux_valid;
  logic                   r_disp_miss;

`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] r_starve_cnt;

  assign w_force = i_aux_req && (r_starve_cnt == 8'(STARVE_MAX));

  always_ff @(posedge i_pclk) begin
    if (!i_rst)
      r_starve_cnt <= 8'd0;
    else if (!i_aux_req || w_aux_gnt)
      r_starve_cnt <= 8'd0;
    else if (r_starve_cnt != 8'(STARVE_MAX))
      r_starve_cnt <= r_starve_cnt + 8'd1;
  end
`else
  assign w_force = 1'b0;
`endif

  // Grants are masked during reset so nothing enters the pipe then.
  assign w_aux_gnt  = i_rst && i_aux_req && (!i_disp_req || w_force);
  assign w_disp_gnt = i_rst && i_disp_req && !w_force;
  assign o_aux_gnt  = w_aux_gnt;

  always_comb begin
    w_tag_in = TAG_NONE;
    if (w_aux_gnt)
      w_tag_in = i_disp_req ? TAG_MISS : TAG_AUX;
    else if (w_disp_gnt)
      w_tag_in = TAG_DISP;
  end

  always_ff @(posedge i_pclk) begin
    if (!i_rst) begin
      r_rom_addr <= '0;
      r_tag      <= '0;
    end else begin
      if (w_aux_gnt)
        r_rom_addr <= i_aux_addr;
      else if (w_disp_gnt)
        r_rom_addr <= i_disp_addr;
      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= ROM_LAT; i++)
        r_tag[i] <= r_tag[i-1];
    end
  end

  // The tag at the pipe tail lines up with i_rom_rgb for the same read.
  always_ff @(posedge i_pclk) begin
    if (!i_rst) begin
      r_disp_rgb   <= '0;
      r_aux_rgb    <= '0;
      r_disp_valid <= 1'b0;
      r_aux_valid  <= 1'b0;
      r_disp_miss  <= 1'b0;
    end else begin
      r_disp_valid <= 1'b0;
      r_aux_valid  <= 1'b0;
      r_disp_miss  <= 1'b0;
      case (r_tag[ROM_LAT])
        TAG_DISP: begin
          r_disp_rgb   <= i_rom_rgb;
          r_disp_valid <= 1'b1;
        end
        TAG_AUX: begin
          r_aux_rgb   <= i_rom_rgb;
          r_aux_valid <= 1'b1;
        end
        TAG_MISS: r_disp_miss <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_disp_rgb   = r_disp_rgb;
  assign o_aux_rgb    = r_aux_rgb;
  assign o_disp_valid = r_disp_valid;
  assign o_aux_valid  = r_aux_valid;
  assign o_disp_miss  = r_disp_miss;

endmodule

// File: doc/image_rom_arbiter.md
# image_rom_arbiter

Shares the single synchronous-read port of `image_rom` between two requesters. The display requester is the `draw_react` pixel pipeline, which reads every active-video cycle. The auxiliary requester is a background engine, e.g. a sprite-hit or copy engine, that reads only when the display pipeline is idle. The block sits between the requesters and `image_rom` in the `pclk` domain. It returns each read to its owner with a fixed, known latency, and it enforces a starvation guard on the auxiliary port.

## Interface
Parameters:
- `ADDR_W`, 12, ROM address width
- `DATA_W`, 12, ROM data width (RGB 4:4:4)
- `ROM_LAT`, 1, ROM read latency in cycles (address registered → data valid); legal range 1–4
- `STARVE_MAX`, 15, consecutive denied aux cycles before a forced aux grant; legal range 1–255

Ports (one clock; reset is synchronous and active-low):
- `pclk`  in  1  pixel clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-low reset
- `disp_req`  in  1  display read request, one read per cycle while high
- `disp_addr`  in  ADDR_W  display read address
- `disp_rgb`  out  DATA_W  display read data
- `disp_valid`  out  1  `disp_rgb` updated this cycle
- `disp_miss`  out  1  display read was pre-empted; `disp_rgb` holds its previous value
- `aux_req`  in  1  aux read request; hold `aux_req` and `aux_addr` stable until granted
- `aux_addr`  in  ADDR_W  aux read address
- `aux_gnt`  out  1  combinational; the aux read is accepted on this edge
- `aux_rgb`  out  DATA_W  aux read data
- `aux_valid`  out  1  `aux_rgb` updated this cycle
- `rom_addr`  out  ADDR_W  registered address to `image_rom`
- `rom_rgb`  in  DATA_W  `image_rom` data

## Operation
- Grant is decided each cycle t, combinationally:
  - `force = aux_req && (starve_cnt == STARVE_MAX)`
  - `aux_gnt = aux_req && (!disp_req || force)`
  - The display is granted when `disp_req && !force`.
  - With no request, there is no grant.
- `rom_addr`:
  - Registers the winning address at t+1.
  - Holds its last value when no grant is made.
- Owner tag pipeline:
  - A shift register of depth ROM_LAT+1 carries the 2-bit owner code {none, disp, aux, disp_preempted}.
  - A `disp_preempted` tag is inserted when `disp_req && force`.
- Return stage, registered at t+ROM_LAT+2:
  - Tag `disp`: `disp_rgb <= rom_rgb`, `disp_valid = 1`.
  - Tag `aux`: `aux_rgb <= rom_rgb`, `aux_valid = 1`.
  - Tag `disp_preempted`: `disp_miss = 1`, `disp_valid = 0`, `disp_rgb` held.
  - `disp_valid`, `aux_valid` and `disp_miss` are single-cycle and mutually exclusive.
- Starvation counter `starve_cnt`, 8 bits:
  - Cleared when `!aux_req` or on `aux_gnt`.
  - Incremented when `aux_req && !aux_gnt`.
  - Saturates at STARVE_MAX.
- Reset (`rst == 0` at an edge):
  - All outputs go to 0, and `starve_cnt`, the tags and `rom_addr` go to 0.
  - In-flight reads are discarded; no valid or miss pulse is produced for them after release.
  - `aux_gnt` is forced to 0 while reset is asserted.

## Timing
- Request-to-data latency is ROM_LAT+2 cycles for both ports (3 at default).
- Throughput is one ROM read per cycle, with no bubbles between owners.
- Under sustained `disp_req` with `aux_req` high, aux is granted every STARVE_MAX+1 cycles.
- `disp_req` high and `aux_req` low: the display gets every cycle, and the counter stays 0.
- The first cycle after reset release can grant, with data valid at ROM_LAT+2.

## Configuration
- `ARB_STARVE_GUARD_EN` defined:
  - The starvation counter and forced aux grant are present, as above.
- Not defined:
  - Strict display priority; `force` is constant 0 and the counter is removed.
  - `disp_miss` is tied to 0.
  - Aux is served only in cycles where `disp_req` is low, so it may wait indefinitely.

## Test plan
- Display-only stream: `disp_addr` = 0,1,2… for 10 cycles with an incrementing-data ROM model → `disp_valid` for 10 cycles starting 3 cycles later, data 0,1,2…, `aux_valid` stays 0.
- Aux-only: `aux_req` with `aux_addr`=0x123 → `aux_gnt` the same cycle, `rom_addr`=0x123 next cycle, `aux_valid` with ROM[0x123] 3 cycles after the request.
- Starvation (macro defined, STARVE_MAX=15): `disp_req` held high and `aux_req` high from cycle 0 → `aux_gnt` at cycle 15, with `disp_miss` at cycle 18 and `disp_rgb` unchanged; then `aux_req` low → no further misses.
- Macro undefined, same stimulus → `aux_gnt` is never asserted while `disp_req` is high and `disp_miss` stays 0; dropping `disp_req` → `aux_gnt` the same cycle.
- Alternating owners every cycle (display during active video, aux during blanking, switched per cycle) → each return is routed to the correct port and there are no lost reads.
- Reset mid-stream: `rst` low for 1 cycle with 2 reads in flight → no valid or miss pulses for those reads, all outputs 0, and a new read after release returns in 3 cycles.
